// File: rtl/rejestry_pkg.sv
// +----------------------------------------------------------------------------+
// | rejestry_pkg                                                               |
// | Shared constants and types for the 2-read / 1-write register file.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rejestry_pkg;

  localparam int RX_LICZBA_DEF    = 8;
  localparam int RX_ROZM_DATA_DEF = 8;

  typedef logic [$clog2(RX_LICZBA_DEF)-1:0] rx_addr_t;
  typedef logic [RX_ROZM_DATA_DEF-1:0]      rx_data_t;

  typedef struct packed {
    rx_data_t data;
    logic     busy;
    logic     valid;
  } rd_resp_t;

endpackage

`default_nettype wire

// File: rtl/rejestry_port_odczytu.sv
// +----------------------------------------------------------------------------+
// | rejestry_port_odczytu                                                      |
// | One registered read port: write/reserve bypass and register-0 masking.    |
// | Optional feature: REJESTRY_BYPASS_EN (same-cycle write forwarding).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rejestry_port_odczytu
  import rejestry_pkg::*;
#(
  parameter int RX_LICZBA    = RX_LICZBA_DEF,
  parameter int RX_ROZM_DATA = RX_ROZM_DATA_DEF,
  parameter bit ZERO_R0      = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_en_i,
  input  logic [$clog2(RX_LICZBA)-1:0] rd_addr_i,
  input  logic [RX_ROZM_DATA-1:0]      mem_data_i,
  input  logic                         mem_busy_i,
  input  logic                         wr_en_i,
  input  logic [$clog2(RX_LICZBA)-1:0] wr_addr_i,
  input  logic [RX_ROZM_DATA-1:0]      wr_data_i,
  input  logic                         rsv_en_i,
  input  logic [$clog2(RX_LICZBA)-1:0] rsv_addr_i,
  output logic [RX_ROZM_DATA-1:0]      rd_data_o,
  output logic                         rd_busy_o,
  output logic                         rd_valid_o
);

  typedef struct packed {
    logic [RX_ROZM_DATA-1:0] data;
    logic                    busy;
    logic                    valid;
  } resp_t;

  resp_t                   resp_q, resp_d;
  logic [RX_ROZM_DATA-1:0] sel_data;
  logic                    sel_busy;

`ifndef REJESTRY_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{wr_en_i, wr_addr_i, wr_data_i, rsv_en_i, rsv_addr_i};
`endif

  always_comb begin
    sel_data = mem_data_i;
    sel_busy = mem_busy_i;
`ifdef REJESTRY_BYPASS_EN
    // Reserve is applied after write so a same-address reserve leaves busy set.
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      sel_data = wr_data_i;
      sel_busy = 1'b0;
    end
    if (rsv_en_i && (rsv_addr_i == rd_addr_i)) begin
      sel_busy = 1'b1;
    end
`endif
    if (ZERO_R0 && (rd_addr_i == '0)) begin
      sel_data = '0;
      sel_busy = 1'b0;
    end

    resp_d       = resp_q;
    resp_d.valid = 1'b0;
    if (rd_en_i) begin
      resp_d = '{data: sel_data, busy: sel_busy, valid: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  assign rd_data_o  = resp_q.data;
  assign rd_busy_o  = resp_q.busy;
  assign rd_valid_o = resp_q.valid;

endmodule

`default_nettype wire

// File: rtl/rejestry_2r1w.sv
// +----------------------------------------------------------------------------+
// | rejestry_2r1w                                                              |
// | Register file, 1 write / 2 registered read ports, per-register busy bits. |
// | Optional feature: REJESTRY_BYPASS_EN (same-cycle write forwarding).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rejestry_2r1w
  import rejestry_pkg::*;
#(
  parameter int RX_LICZBA    = RX_LICZBA_DEF,
  parameter int RX_ROZM_DATA = RX_ROZM_DATA_DEF,
  parameter bit ZERO_R0      = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(RX_LICZBA)-1:0] wr_addr,
  input  logic [RX_ROZM_DATA-1:0]      wr_data,
  input  logic                         rsv_en,
  input  logic [$clog2(RX_LICZBA)-1:0] rsv_addr,
  input  logic                         rd_en_a,
  input  logic [$clog2(RX_LICZBA)-1:0] rd_addr_a,
  output logic [RX_ROZM_DATA-1:0]      rd_data_a,
  output logic                         rd_busy_a,
  output logic                         rd_valid_a,
  input  logic                         rd_en_b,
  input  logic [$clog2(RX_LICZBA)-1:0] rd_addr_b,
  output logic [RX_ROZM_DATA-1:0]      rd_data_b,
  output logic                         rd_busy_b,
  output logic                         rd_valid_b
);

  logic [RX_ROZM_DATA-1:0] regs_q [RX_LICZBA];
  logic [RX_LICZBA-1:0]    busy_q, busy_d;
  logic                    wr_ok, rsv_ok;

  // Register 0 is hard-wired when ZERO_R0 is set, so its updates are dropped here.
  assign wr_ok  = wr_en  && !(ZERO_R0 && (wr_addr  == '0));
  assign rsv_ok = rsv_en && !(ZERO_R0 && (rsv_addr == '0));

  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < RX_LICZBA; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      if (wr_ok) begin
        regs_q[wr_addr] <= wr_data;
      end
    end
  end

  rejestry_port_odczytu #(
    .RX_LICZBA    (RX_LICZBA),
    .RX_ROZM_DATA (RX_ROZM_DATA),
    .ZERO_R0      (ZERO_R0)
  ) u_port_a (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (rd_en_a),
    .rd_addr_i  (rd_addr_a),
    .mem_data_i (regs_q[rd_addr_a]),
    .mem_busy_i (busy_q[rd_addr_a]),
    .wr_en_i    (wr_ok),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rsv_en_i   (rsv_ok),
    .rsv_addr_i (rsv_addr),
    .rd_data_o  (rd_data_a),
    .rd_busy_o  (rd_busy_a),
    .rd_valid_o (rd_valid_a)
  );

  rejestry_port_odczytu #(
    .RX_LICZBA    (RX_LICZBA),
    .RX_ROZM_DATA (RX_ROZM_DATA),
    .ZERO_R0      (ZERO_R0)
  ) u_port_b (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    (rd_en_b),
    .rd_addr_i  (rd_addr_b),
    .mem_data_i (regs_q[rd_addr_b]),
    .mem_busy_i (busy_q[rd_addr_b]),
    .wr_en_i    (wr_ok),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rsv_en_i   (rsv_ok),
    .rsv_addr_i (rsv_addr),
    .rd_data_o  (rd_data_b),
    .rd_busy_o  (rd_busy_b),
    .rd_valid_o (rd_valid_b)
  );

endmodule

`default_nettype wire
